// File: rtl/mdu_if.sv
// Handshake and shared-ALU signal bundle between the core and the mdu_seq sequencer.
// master = core/datapath side, slave = sequencer side.
interface mdu_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic            busy;
  logic            done;
  logic            err;
  logic [XLEN-1:0] result;
  logic            alu_own;
  logic [XLEN-1:0] alu_src_a;
  logic [XLEN-1:0] alu_src_b;
  logic [3:0]      alu_control;
  logic [XLEN-1:0] alu_result;
  logic            alu_blt;

  modport master (
    output start, op, src_a, src_b, alu_result, alu_blt,
    input  busy, done, err, result, alu_own, alu_src_a, alu_src_b, alu_control
  );

  modport slave (
    input  start, op, src_a, src_b, alu_result, alu_blt,
    output busy, done, err, result, alu_own, alu_src_a, alu_src_b, alu_control
  );
endinterface

// File: rtl/mdu_seq.sv
// mdu_seq: multi-cycle RV32M MUL/DIV/DIVU/REM/REMU sequencer that borrows the core's shared ALU.
// Optional MDU_EARLY_OUT_EN: MUL finishes once the remaining multiplier bits are all zero.
module mdu_seq #(
  parameter int XLEN  = 32,
  parameter int ITERS = 32
) (
  input  logic clk,
  input  logic rst_n,
  mdu_if.slave bus
);
  localparam logic [2:0] OP_MUL   = 3'b000;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0111;
  localparam logic [4:0] LAST_CNT = 5'(ITERS - 1);

  typedef enum logic [2:0] {S_IDLE, S_NEG_A, S_NEG_B, S_ITER, S_NEG_R, S_DONE} state_t;

  state_t          r_state, w_state_next;
  logic [2:0]      r_op, w_op_next;
  logic [XLEN-1:0] r_x, w_x_next;      // MUL: multiplicand; divide: dividend shifting into quotient
  logic [XLEN-1:0] r_y, w_y_next;      // MUL: multiplier;   divide: divisor
  logic [XLEN-1:0] r_acc, w_acc_next;  // MUL: product;      divide: partial remainder
  logic [4:0]      r_cnt, w_cnt_next;
  logic            r_sign_a, w_sign_a_next;
  logic            r_sign_b, w_sign_b_next;
  logic            r_err, w_err_next;
  logic [XLEN-1:0] r_result, w_result_next;

  logic            w_busy, w_is_mul, w_is_signed_div, w_neg_r, w_take, w_last;
  logic [XLEN-1:0] w_div_shift, w_neg_r_val, w_alu_a, w_alu_b;
  logic [3:0]      w_alu_ctl;

  assign w_busy          = (r_state != S_IDLE) && (r_state != S_DONE);
  assign w_is_mul        = (r_op == OP_MUL);
  assign w_is_signed_div = r_op[2] & ~r_op[0];
  assign w_div_shift     = {r_acc[XLEN-2:0], r_x[XLEN-1]};
  assign w_neg_r         = r_op[1] ? r_sign_a : (r_sign_a ^ r_sign_b);
  assign w_neg_r_val     = r_op[1] ? r_acc : r_x;

  // Operand steering kept apart from next-state logic so ALU feedback never forms a comb loop.
  always_comb begin
    w_alu_a   = '0;
    w_alu_b   = '0;
    w_alu_ctl = 4'b0000;
    case (r_state)
      S_NEG_A: begin
        w_alu_a   = r_sign_a ? '0 : r_x;
        w_alu_b   = r_sign_a ? r_x : '0;
        w_alu_ctl = r_sign_a ? ALU_SUB : ALU_ADD;
      end
      S_NEG_B: begin
        w_alu_a   = r_sign_b ? '0 : r_y;
        w_alu_b   = r_sign_b ? r_y : '0;
        w_alu_ctl = r_sign_b ? ALU_SUB : ALU_ADD;
      end
      S_ITER: begin
        w_alu_a   = w_is_mul ? r_acc : w_div_shift;
        w_alu_b   = w_is_mul ? r_x : r_y;
        w_alu_ctl = w_is_mul ? ALU_ADD : ALU_SUB;
      end
      S_NEG_R: begin
        w_alu_a   = w_neg_r ? '0 : w_neg_r_val;
        w_alu_b   = w_neg_r ? w_neg_r_val : '0;
        w_alu_ctl = w_neg_r ? ALU_SUB : ALU_ADD;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_state_next  = r_state;
    w_op_next     = r_op;
    w_x_next      = r_x;
    w_y_next      = r_y;
    w_acc_next    = r_acc;
    w_cnt_next    = r_cnt;
    w_sign_a_next = r_sign_a;
    w_sign_b_next = r_sign_b;
    w_err_next    = r_err;
    w_result_next = r_result;
    w_take        = 1'b0;
    w_last        = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        w_state_next = S_IDLE;
        if (bus.start) begin
          w_op_next     = bus.op;
          w_x_next      = bus.src_a;
          w_y_next      = bus.src_b;
          w_acc_next    = '0;
          w_cnt_next    = '0;
          w_sign_a_next = bus.op[2] & ~bus.op[0] & bus.src_a[XLEN-1];
          w_sign_b_next = bus.op[2] & ~bus.op[0] & bus.src_b[XLEN-1];
          w_err_next    = 1'b0;
          if (!bus.op[2] && bus.op != OP_MUL) begin
            w_err_next    = 1'b1;
            w_result_next = '0;
            w_state_next  = S_DONE;
          end else if (bus.op[2] && bus.src_b == '0) begin
            w_result_next = bus.op[1] ? bus.src_a : '1;
            w_state_next  = S_DONE;
`ifdef MDU_EARLY_OUT_EN
          end else if (bus.op == OP_MUL && bus.src_b == '0) begin
            w_result_next = '0;
            w_state_next  = S_DONE;
`endif
          end else if (bus.op[2] && !bus.op[0]) begin
            w_state_next = S_NEG_A;
          end else begin
            w_state_next = S_ITER;
          end
        end
      end
      S_NEG_A: begin
        w_x_next     = bus.alu_result;
        w_state_next = S_NEG_B;
      end
      S_NEG_B: begin
        w_y_next     = bus.alu_result;
        w_state_next = S_ITER;
      end
      S_ITER: begin
        if (w_is_mul) begin
          w_acc_next = r_y[0] ? bus.alu_result : r_acc;
          w_x_next   = r_x << 1;
          w_y_next   = r_y >> 1;
        end else begin
          // Restoring step: the carry out of the shift means the partial remainder already exceeds the divisor.
          w_take     = r_acc[XLEN-1] | ~bus.alu_blt;
          w_acc_next = w_take ? bus.alu_result : w_div_shift;
          w_x_next   = {r_x[XLEN-2:0], w_take};
        end
        w_last = (r_cnt == LAST_CNT);
`ifdef MDU_EARLY_OUT_EN
        if (w_is_mul && w_y_next == '0) w_last = 1'b1;
`endif
        if (w_last) begin
          if (w_is_signed_div) begin
            w_state_next = S_NEG_R;
          end else begin
            w_result_next = (!w_is_mul && !r_op[1]) ? w_x_next : w_acc_next;
            w_state_next  = S_DONE;
          end
        end else begin
          w_cnt_next = r_cnt + 5'd1;
        end
      end
      S_NEG_R: begin
        w_result_next = bus.alu_result;
        w_state_next  = S_DONE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_op     <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_err    <= 1'b0;
      r_result <= '0;
    end else begin
      r_state  <= w_state_next;
      r_op     <= w_op_next;
      r_x      <= w_x_next;
      r_y      <= w_y_next;
      r_acc    <= w_acc_next;
      r_cnt    <= w_cnt_next;
      r_sign_a <= w_sign_a_next;
      r_sign_b <= w_sign_b_next;
      r_err    <= w_err_next;
      r_result <= w_result_next;
    end
  end

  assign bus.busy        = w_busy;
  assign bus.alu_own     = w_busy;
  assign bus.done        = (r_state == S_DONE);
  assign bus.err         = (r_state == S_DONE) & r_err;
  assign bus.result      = r_result;
  assign bus.alu_src_a   = w_alu_a;
  assign bus.alu_src_b   = w_alu_b;
  assign bus.alu_control = w_alu_ctl;
endmodule

// File: tb/tb_mdu_seq.sv
// Scoreboard bench for mdu_seq: stimulus pushes expected {result, err, done cycle}; a monitor
// pops and compares on every done pulse. Includes a behavioural model of the shared ALU.
module tb_mdu_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  mdu_if bus();

  mdu_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Shared ALU as the core provides it: ADD and unsigned SUB/compare.
  always_comb begin
    bus.alu_result = '0;
    bus.alu_blt    = 1'b0;
    case (bus.alu_control)
      4'b0010: bus.alu_result = bus.alu_src_a + bus.alu_src_b;
      4'b0111: begin
        bus.alu_result = bus.alu_src_a - bus.alu_src_b;
        bus.alu_blt    = (bus.alu_src_a < bus.alu_src_b);
      end
      default: ;
    endcase
  end

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        err;
    int          due;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // RV32M semantics from plain arithmetic: {err, result}.
  function automatic logic [32:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ma, mb, q, r;
    case (op)
      3'b000: return {1'b0, a * b};
      3'b101: return {1'b0, (b == 0) ? 32'hFFFF_FFFF : a / b};
      3'b111: return {1'b0, (b == 0) ? a : a % b};
      3'b100, 3'b110: begin
        if (b == 0) return {1'b0, op[1] ? a : 32'hFFFF_FFFF};
        ma = a[31] ? -a : a;
        mb = b[31] ? -b : b;
        q  = ma / mb;
        r  = ma % mb;
        if (op[1]) return {1'b0, a[31] ? -r : r};
        return {1'b0, (a[31] ^ b[31]) ? -q : q};
      end
      default: return {1'b1, 32'h0};
    endcase
  endfunction

  function automatic int lat(input logic [2:0] op, input logic [31:0] b);
    if (!op[2] && op != 3'b000) return 1;
    if (op[2] && b == 0) return 1;
    if (op == 3'b100 || op == 3'b110) return 36;
`ifdef MDU_EARLY_OUT_EN
    if (op == 3'b000) begin
      if (b == 0) return 1;
      for (int i = 31; i >= 0; i--) if (b[i]) return i + 2;
    end
`endif
    return 33;
  endfunction

  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL spurious_done: got done=1 result=%h, expected no done (cycle %0d)", bus.result, cyc);
      end else begin
        mon_e = sb_q.pop_front();
        check("result", bus.result, mon_e.res);
        check("err", 32'(bus.err), 32'(mon_e.err));
        check("done_cycle", 32'(cyc), 32'(mon_e.due));
        $display("TXN op=%b a=%h b=%h result=%h err=%b cycle=%0d", mon_e.op, mon_e.a, mon_e.b,
                 bus.result, bus.err, cyc);
      end
    end
  end

  // Called at a negedge; leaves the bench at the negedge of cycle 1.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [32:0] m;
    int          l;
    m     = model(op, a, b);
    l     = lat(op, b);
    e.op  = op;
    e.a   = a;
    e.b   = b;
    e.res = m[31:0];
    e.err = m[32];
    e.due = cyc + l;
    sb_q.push_back(e);
    bus.start = 1'b1;
    bus.op    = op;
    bus.src_a = a;
    bus.src_b = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.op    = 3'($urandom);
    bus.src_a = $urandom;
    bus.src_b = $urandom;
    check("busy_cycle1", 32'(bus.busy), 32'(l > 1));
    check("alu_own_cycle1", 32'(bus.alu_own), 32'(l > 1));
  endtask

  task automatic wait_done();
    int n = 0;
    while (!bus.done && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.done) begin
      n_tests++;
      n_fail++;
      $display("FAIL done_timeout: got no done in 100 cycles, expected a done pulse (cycle %0d)", cyc);
      sb_q.delete();
    end
  endtask

  task automatic run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    issue(op, a, b);
    wait_done();
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [2:0] pick_op();
    case ($urandom_range(0, 9))
      0, 1: return 3'b000;
      2:    return 3'b100;
      3:    return 3'b101;
      4:    return 3'b110;
      5:    return 3'b111;
      6:    return 3'b100;
      7:    return 3'b101;
      8:    return 3'b001;
      default: return 3'b011;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected completion within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0;
    bus.op    = 3'b000;
    bus.src_a = '0;
    bus.src_b = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_alu_own", 32'(bus.alu_own), 32'd0);
    check("rst_result", bus.result, 32'd0);
    check("rst_alu_ctl", 32'(bus.alu_control), 32'd0);
    check("rst_alu_a", bus.alu_src_a, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases; each new op starts in the DONE cycle of the previous one.
    run(3'b000, 32'd7, 32'd6);
    run(3'b101, 32'd100, 32'd7);
    run(3'b111, 32'd100, 32'd7);
    run(3'b100, 32'hFFFF_FFF9, 32'd2);
    run(3'b110, 32'hFFFF_FFF9, 32'd2);
    run(3'b100, 32'd5, 32'd0);
    run(3'b111, 32'd5, 32'd0);
    run(3'b100, 32'h8000_0000, 32'hFFFF_FFFF);
    run(3'b110, 32'h8000_0000, 32'hFFFF_FFFF);
    run(3'b001, 32'd9, 32'd3);
    run(3'b000, 32'd5, 32'd9);
    run(3'b101, 32'hFFFF_FFFF, 32'h8000_0001);

    // Start while busy must be ignored.
    issue(3'b101, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 3'b000;
    bus.src_a = $urandom;
    bus.src_b = $urandom;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done();

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      run(pick_op(), pick(), pick());
    end

    // Asynchronous reset in the middle of a MUL.
    @(negedge clk);
    run(3'b101, 32'd100, 32'd7);
    issue(3'b000, 32'h0000_1234, 32'h8000_5678);
    repeat (14) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_result", bus.result, 32'd0);
    check("abort_alu_own", 32'(bus.alu_own), 32'd0);
    sb_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_abort_done", 32'(bus.done), 32'd0);
    run(3'b000, 32'd3, 32'd4);
    repeat (3) @(negedge clk);

    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mdu_seq.md
Name: mdu_seq

Overview:
- Multi-cycle multiply/divide sequencer (RV32M subset: MUL, DIV, DIVU, REM, REMU).
- Owns no adder. It borrows the core's shared ALU for one operation per cycle, using ADD (4'b0010) and unsigned subtract/compare (4'b0111, which returns Con_BLT).
- The core stalls while busy is high; the datapath muxes the ALU inputs to this block while alu_own is high.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- ITERS, 32, shift/add or shift/subtract iterations; must equal XLEN.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request pulse; sampled only in IDLE or DONE
- op  in  3  RV32M funct3: 000 MUL, 100 DIV, 101 DIVU, 110 REM, 111 REMU; others unsupported
- src_a  in  32  dividend / multiplicand, captured on accepted start
- src_b  in  32  divisor / multiplier, captured on accepted start
- busy  out  1  high in every state except IDLE and DONE
- done  out  1  one-cycle pulse; result valid in that cycle
- err  out  1  high together with done for an unsupported op
- result  out  32  holds its value until the next accepted start
- alu_own  out  1  equals busy
- alu_src_a  out  32  ALU operand A
- alu_src_b  out  32  ALU operand B
- alu_control  out  4  ALU opcode
- alu_result  in  32  ALU result (combinational, same cycle)
- alu_blt  in  1  ALU Con_BLT (unsigned A<B under 4'b0111)

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy, done, err, alu_own = 0; result = 0; all internal registers = 0.
- ALU outputs when not busy: alu_src_a=0, alu_src_b=0, alu_control=4'b0000.
- States: IDLE, NEG_A, NEG_B, ITER, NEG_R, DONE.
- Cycle numbering: cycle 0 is the cycle in which start=1 is sampled.
- Start acceptance: start in IDLE or DONE is accepted; op, src_a and src_b are registered at the end of cycle 0. start while busy is ignored.
- DONE: lasts exactly one cycle. Exits to IDLE, or straight into a new operation if start is accepted there. This allows back-to-back operations.
- Unsupported op: DONE in cycle 1 with err=1 and result=0.
- Divide by zero (src_b==0, any divide op): DONE in cycle 1, no iteration.
  - DIV/DIVU: result=32'hFFFF_FFFF.
  - REM/REMU: result=src_a.
- MUL, DIVU, REMU: ITER in cycles 1..32, DONE in cycle 33.
- DIV, REM (fixed latency regardless of operand signs):
  - NEG_A in cycle 1: if src_a[31]=1, the ALU computes 0-a (4'b0111); otherwise a+0 (4'b0010). The result replaces a.
  - NEG_B in cycle 2: same operation on b.
  - ITER in cycles 3..34.
  - NEG_R in cycle 35: negate the quotient if sign_a^sign_b (DIV); negate the remainder if sign_a (REM).
  - DONE in cycle 36.
- MUL iteration:
  - alu_src_a=acc, alu_src_b=mcand, alu_control=4'b0010.
  - If mplier[0]=1, acc<=alu_result.
  - Then mcand<<=1, mplier>>=1.
  - Result is the low 32 bits of the product; overflow wraps.
- DIVU/REMU iteration (restoring division):
  - shifted={rem[30:0],quo[31]}; carry=rem[31].
  - alu_src_a=shifted, alu_src_b=divisor, alu_control=4'b0111.
  - If carry|~alu_blt: rem<=alu_result and quo<={quo[30:0],1'b1}.
  - Otherwise: rem<=shifted and quo<={quo[30:0],1'b0}.
  - Initial state: rem=0, quo=dividend.
- Iteration counter: 5 bits. ITER exits when the counter reaches ITERS-1 and never wraps.
- Signed overflow (32'h8000_0000 / 32'hFFFF_FFFF): DIV gives 32'h8000_0000, REM gives 0. This falls out of the normal path with no special case.
- Reset mid-operation: immediate abort to IDLE. No done pulse; result is cleared to 0.

Optional Feature:
- Macro: MDU_EARLY_OUT_EN.
- Defined, for MUL only:
  - If src_b==0 at start, go to DONE in cycle 1 with result=0.
  - In ITER, exit to DONE after the cycle in which the shifted mplier becomes 0.
  - Latency is therefore 1 + (index of the highest set bit of src_b) + 1.
- Not defined: MUL always takes 32 ITER cycles (DONE in cycle 33).
- Divide ops are identical with or without the macro.

Test Plan:
- MUL src_a=7, src_b=6 -> done in cycle 33 (no macro), result=42, err=0, busy high in cycles 1..32. With MDU_EARLY_OUT_EN: done in cycle 4, result=42.
- DIVU 100/7 -> result=14 in cycle 33; REMU 100/7 -> 2. DIV -7/2 -> 32'hFFFF_FFFD in cycle 36; REM -7/2 -> 32'hFFFF_FFFF.
- DIV 5/0 -> 32'hFFFF_FFFF in cycle 1; REMU 5/0 -> 5 in cycle 1. DIV 32'h8000_0000/32'hFFFF_FFFF -> 32'h8000_0000; REM of the same -> 0.
- op=3'b001 -> done and err in cycle 1, result=0. Assert start again in the DONE cycle -> the new op is accepted, with no IDLE cycle between.
- start pulsed in cycle 10 of a DIVU -> ignored; the original result is unchanged at cycle 33.
- rst_n low in cycle 15 of a MUL -> async clear: busy=0, result=0, no done pulse. A fresh MUL 3*4 afterwards -> 12.
